// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// the operation-legality helper.
package lsu_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned F3_W   = 3;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;
    localparam logic [F3_W-1:0] F3_SB  = 3'b000;
    localparam logic [F3_W-1:0] F3_SH  = 3'b001;
    localparam logic [F3_W-1:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Exactly one of read/write must be set, and funct3 must name a width that op supports.
    function automatic logic lsu_illegal(input logic rd, input logic wr, input logic [F3_W-1:0] f3);
        logic ld_ok;
        logic st_ok;
        ld_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                (f3 == F3_LBU) || (f3 == F3_LHU);
        st_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (rd == wr) || (rd && !ld_ok) || (wr && !st_ok);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data bus: store enables/replicated data, load
// extraction with sign/zero extension, and the alignment check.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [F3_W-1:0]   funct3,
    input  logic [1:0]        off,
    input  logic              is_store,
    input  logic [XLEN_W-1:0] rs2_data,
    input  logic [XLEN_W-1:0] rdata,
    output logic [BE_W-1:0]   be_c,
    output logic [XLEN_W-1:0] wdata_c,
    output logic [XLEN_W-1:0] load_c,
    output logic              misaligned_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(rdata >> {off, 3'b000});
    assign half_v = off[1] ? rdata[31:16] : rdata[15:0];

    // funct3[1:0] selects width, funct3[2] selects zero extension for loads.
    always_comb begin
        be_c         = 4'b1111;
        wdata_c      = rs2_data;
        load_c       = rdata;
        misaligned_c = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                if (is_store) begin
                    be_c    = 4'b0001 << off;
                    wdata_c = {4{rs2_data[7:0]}};
                end
                load_c = funct3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            2'b01: begin
                misaligned_c = off[0];
                if (is_store) begin
                    be_c    = 4'b0011 << off;
                    wdata_c = {2{rs2_data[15:0]}};
                end
                load_c = funct3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                misaligned_c = |off;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one handshaked data-bus transaction per start.
// Optional request timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            illegal_op,
    output logic            bus_error,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata
);

    lsu_state_e state_q, state_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic            mis_q, mis_d;
    logic            ill_q, ill_d;
    logic            berr_q, berr_d;
    logic [XLEN-1:0] load_q, load_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic            is_load_q, is_load_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    logic            in_idle_c;
    logic [2:0]      al_f3_c;
    logic [1:0]      al_off_c;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] load_c;
    logic            mis_c;
    logic            ill_c;

    // Lane logic sees live inputs while deciding in IDLE, captured ones while extracting in REQ.
    assign in_idle_c = (state_q == ST_IDLE);
    assign al_f3_c   = in_idle_c ? funct3 : f3_q;
    assign al_off_c  = in_idle_c ? alu_result[1:0] : off_q;
    assign ill_c     = lsu_illegal(mem_read, mem_write, funct3);

    lsu_lane_align u_align (
        .funct3       (al_f3_c),
        .off          (al_off_c),
        .is_store     (mem_write & ~mem_read),
        .rs2_data     (rs2_data),
        .rdata        (dmem_rdata),
        .be_c         (be_c),
        .wdata_c      (wdata_c),
        .load_c       (load_c),
        .misaligned_c (mis_c)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        req_d     = req_q;
        we_d      = we_q;
        mis_d     = mis_q;
        ill_d     = ill_q;
        berr_d    = berr_q;
        load_d    = load_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        f3_d      = f3_q;
        off_d     = off_q;
        is_load_d = is_load_q;
`ifdef LSU_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    f3_d      = funct3;
                    off_d     = alu_result[1:0];
                    is_load_d = mem_read & ~mem_write;
                    busy_d    = 1'b1;
                    ill_d     = 1'b0;
                    mis_d     = 1'b0;
                    berr_d    = 1'b0;
                    load_d    = '0;
                    if (ill_c) begin
                        ill_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (mis_c) begin
                        mis_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {alu_result[XLEN-1:2], 2'b00};
                        wdata_d = wdata_c;
                        be_d    = be_c;
                        state_d = ST_REQ;
`ifdef LSU_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    load_d  = is_load_q ? load_c : '0;
                    state_d = ST_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                // A ready arriving on the limit cycle is taken by the branch above.
                else if (tmo_q + TMO_W'(1) == TMO_W'(TIMEOUT_CYCLES)) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    berr_d  = 1'b1;
                    done_d  = 1'b1;
                    load_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            ST_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            mis_q     <= 1'b0;
            ill_q     <= 1'b0;
            berr_q    <= 1'b0;
            load_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            is_load_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            req_q     <= req_d;
            we_q      <= we_d;
            mis_q     <= mis_d;
            ill_q     <= ill_d;
            berr_q    <= berr_d;
            load_q    <= load_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            is_load_q <= is_load_d;
`ifdef LSU_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign load_data  = load_q;
    assign misaligned = mis_q;
    assign illegal_op = ill_q;
    assign bus_error  = berr_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic
// model of the lane/extension/fault rules.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        illegal_op;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    int n_checks;
    int n_fail;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .alu_result (alu_result),
        .rs2_data   (rs2_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: access size in bytes, lanes by shifting, extension by arithmetic.
    task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                         output logic e_ill, output logic e_mis, output logic [3:0] e_be,
                         output logic [31:0] e_wd, output logic [31:0] e_ld);
        int unsigned size;
        int unsigned off;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = addr % 4;
        e_ill = (rd == wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 > 2);
        e_mis = !e_ill && ((addr % size) != 0);
        e_be  = rd ? 4'hF : 4'(((1 << size) - 1) << off);
        if (size == 1)      e_wd = rs2[7:0] * 32'h0101_0101;
        else if (size == 2) e_wd = rs2[15:0] * 32'h0001_0001;
        else                e_wd = rs2;
        if (size == 4) begin
            v = rdata;
        end else begin
            v = (rdata >> (8 * (off - off % size))) & ((32'd1 << (8 * size)) - 32'd1);
            if (f3 < 4 && v >= (32'd1 << (8 * size - 1)))
                v = v - (32'd1 << (8 * size));
        end
        e_ld = v;
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                          input int waits, input bit poke);
        logic        e_ill, e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ld, e_fin_ld;
        bit          tmo;
        int          cycles;
        model(rd, wr, f3, addr, rs2, rdata, e_ill, e_mis, e_be, e_wd, e_ld);
        tmo    = TMO_EN && !e_ill && !e_mis && (waits >= TMO);
        cycles = tmo ? TMO : waits + 1;
        e_fin_ld = (rd && !wr && !e_ill && !e_mis && !tmo) ? e_ld : 32'h0;

        @(negedge clk);
        start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = addr; rs2_data = rs2;
        @(negedge clk);
        start = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
        funct3 = 3'($urandom); alu_result = $urandom; rs2_data = $urandom;

        if (e_ill || e_mis) begin
            check_eq("flt_done", done, 1);
            check_eq("flt_req", dmem_req, 0);
            check_eq("flt_busy", busy, 1);
            check_eq("flt_ill", illegal_op, e_ill);
            check_eq("flt_mis", misaligned, e_mis);
            check_eq("flt_berr", bus_error, 0);
            check_eq("flt_ld", load_data, 0);
        end else begin
            for (int k = 0; k < cycles; k++) begin
                check_eq("req", dmem_req, 1);
                check_eq("busy", busy, 1);
                check_eq("no_done", done, 0);
                check_eq("addr", dmem_addr, {addr[31:2], 2'b00});
                check_eq("we", dmem_we, wr);
                check_eq("be", dmem_be, e_be);
                if (wr) check_eq("wdata", dmem_wdata, e_wd);
                dmem_ready = !tmo && (k == waits);
                dmem_rdata = dmem_ready ? rdata : $urandom;
                if (poke && k == 0) begin
                    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
                    funct3 = 3'b010; alu_result = addr ^ 32'h40;
                end
                @(negedge clk);
                dmem_ready = 1'b0;
                start = 1'b0;
            end
            check_eq("done", done, 1);
            check_eq("done_req", dmem_req, 0);
            check_eq("done_busy", busy, 1);
            check_eq("done_ill", illegal_op, 0);
            check_eq("done_mis", misaligned, 0);
            check_eq("done_berr", bus_error, tmo);
            check_eq("load_data", load_data, e_fin_ld);
            if (poke) check_eq("poke_addr", dmem_addr, {addr[31:2], 2'b00});
        end

        @(negedge clk);
        check_eq("post_done", done, 0);
        check_eq("post_busy", busy, 0);
        check_eq("post_req", dmem_req, 0);
        check_eq("hold_ld", load_data, e_fin_ld);
        check_eq("hold_ill", illegal_op, e_ill);
        check_eq("hold_mis", misaligned, e_mis);
    endtask

    task automatic reset_mid_req();
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h0000_0400;
        @(negedge clk);
        start = 1'b0;
        check_eq("rq_req", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_addr", dmem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_done", done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        alu_result = '0; rs2_data = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy0", busy, 0);
        check_eq("rst_done0", done, 0);
        check_eq("rst_req0", dmem_req, 0);
        check_eq("rst_we0", dmem_we, 0);
        check_eq("rst_mis0", misaligned, 0);
        check_eq("rst_ill0", illegal_op, 0);
        check_eq("rst_berr0", bus_error, 0);
        check_eq("rst_ld0", load_data, 0);
        check_eq("rst_addr0", dmem_addr, 0);
        check_eq("rst_wd0", dmem_wdata, 0);
        check_eq("rst_be0", dmem_be, 0);
        rst = 1'b0;

        run_op(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        run_op(1, 0, 3'b000, 32'h0000_0203, 32'h0, 32'h8011_2233, 0, 0);
        run_op(1, 0, 3'b100, 32'h0000_0203, 32'h0, 32'h8011_2233, 0, 0);
        run_op(0, 1, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 3, 0);
        run_op(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
        run_op(1, 0, 3'b011, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
        run_op(1, 1, 3'b000, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
        run_op(0, 1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
        run_op(1, 0, 3'b101, 32'h0000_0502, 32'h0, 32'h8765_4321, 1, 0);
        run_op(1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h1234_5678, 2, 1);
        reset_mid_req();
        if (TMO_EN) begin
            run_op(1, 0, 3'b010, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, TMO + 2, 0);
            run_op(1, 0, 3'b010, 32'h0000_0604, 32'h0, 32'hCAFE_F00D, TMO - 1, 0);
        end

        for (int i = 0; i < 60; i++) begin
            int unsigned sel;
            logic rd, wr;
            sel = $urandom_range(0, 9);
            if (sel == 0)      begin rd = 1'b0; wr = 1'b0; end
            else if (sel == 1) begin rd = 1'b1; wr = 1'b1; end
            else if (sel < 6)  begin rd = 1'b1; wr = 1'b0; end
            else               begin rd = 1'b0; wr = 1'b1; end
            run_op(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, TMO_EN ? 6 : 5)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address, plus rs2 as store data.
- Runs one handshaked transaction on the data-memory bus and returns a sign/zero-extended load value toward writeback.
- Multi-cycle; holds the pipeline via busy until done.

Parameters:
- XLEN, 32, data and address width (only 32 supported).
- TIMEOUT_CYCLES, 255, cycles in REQ before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch request, sampled only in IDLE
- mem_read  input  1  operation is a load
- mem_write  input  1  operation is a store
- funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- alu_result  input  32  effective address from ALU
- rs2_data  input  32  store source data
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- load_data  output  32  extended load result, valid while done=1
- misaligned  output  1  valid with done; address misaligned for width
- illegal_op  output  1  valid with done; bad funct3 or read/write combination
- bus_error  output  1  valid with done; timeout abort (0 when the feature is off)
- dmem_req  output  1  bus request
- dmem_we  output  1  write enable
- dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  output  32  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ready  input  1  slave accept; read data valid in the same cycle
- dmem_rdata  input  32  read word

Behaviour:
- Reset (async, rst=1) state and outputs:
  - state=IDLE.
  - busy, done, dmem_req, dmem_we, misaligned, illegal_op, bus_error = 0.
  - load_data, dmem_addr, dmem_wdata, dmem_be = 0.
  - Reset mid-transaction drops dmem_req immediately; no done is produced.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - start=1 captures addr, funct3, mem_read/mem_write and rs2_data into registers.
  - Illegal if:
    - mem_read == mem_write; or
    - load with funct3 ∈ {011,110,111}; or
    - store with funct3 ∉ {000,001,010}.
  - Misaligned if: half with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal or misaligned → DONE with the matching flag set; no bus activity. illegal_op takes priority and misaligned=0 when illegal.
  - Otherwise → REQ.
- REQ:
  - dmem_req=1; dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable until dmem_ready.
  - dmem_ready=1 → DONE. For loads, the extracted value is registered into load_data.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
  - Flags and load_data hold their values until the next start is accepted.
- busy=1 in REQ and DONE.
- start while not in IDLE is ignored.
- Minimum latency: start at cycle N, dmem_req at N+1, done at N+2 (ready in the first REQ cycle). Faults: done at N+1.
- Byte lanes (off = addr[1:0]):
  - SB: be = 0001<<off, wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<off, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
  - Loads: be = 1111, dmem_we = 0.
- Load extract:
  - LB/LBU use rdata byte at lane off, sign/zero extended.
  - LH/LHU use the half at lane off[1], sign/zero extended.
  - LW uses the full word.
- load_data=0 for stores and faults.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit+ counter runs in REQ and clears on entering REQ.
  - When the count reaches TIMEOUT_CYCLES without dmem_ready: drop dmem_req, → DONE with bus_error=1 and load_data=0.
  - dmem_ready in the same cycle as the limit wins; the access completes normally.
- Undefined: no counter; REQ waits indefinitely; bus_error tied 0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101; SB/SH/SW share 000/001/010).
  - State encoding IDLE/REQ/DONE.
- Sub-module lsu_lane_align (combinational): from funct3, off, rs2_data and rdata produces be, wdata, extracted load value and misaligned flag.
- The top holds the FSM, capture registers and the timeout.

Test Plan:
- LW addr=0x100, rdata=0xDEADBEEF, ready on first REQ cycle → dmem_addr=0x100, be=1111, done at N+2, load_data=0xDEADBEEF.
- LB addr=0x203, rdata=0x80112233 → be=1111, load_data=0xFFFFFF80; LBU same → 0x00000080.
- SH addr=0x302, rs2=0x0000ABCD, ready after 3 wait cycles → be=1100, wdata=0xABCDABCD, dmem_we=1, req held 4 cycles, done next cycle.
- LW addr=0x101 → no dmem_req, done at N+1 with misaligned=1. funct3=011 load → illegal_op=1, misaligned=0.
- rst asserted while in REQ → dmem_req=0 and busy=0 immediately, no done. A start issued while busy is ignored (addr unchanged).
- (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4) ready never asserted → done with bus_error=1 after 4 REQ cycles, load_data=0.
